// File: rtl/wide2narrow_gearbox.sv
// Width down-converter: unpacks IN_WIDTH-bit words into OUT_WIDTH-bit beats, LSB beat first.
// Optional macro W2N_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module wide2narrow_gearbox #(
    parameter int IN_WIDTH  = 256,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
`ifdef W2N_UNDERRUN_CNT_EN
    ,
    output logic [15:0]          underrun_cnt
`endif
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    // A one-beat word still needs a 1-bit counter so the compare below stays legal.
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    logic [IN_WIDTH-1:0] act_reg;
    logic [IN_WIDTH-1:0] pend_reg;
    logic                act_vld;
    logic                pend_vld;
    logic [CNT_W-1:0]    beat_cnt;

    logic beat_xfer;
    logic last_xfer;
    logic in_xfer;

    // in_rdy is forced low while reset is asserted, so no word is taken during reset.
    assign in_rdy    = rst_n & ~pend_vld & ~flush;
    assign out_vld   = act_vld;
    assign out_data  = act_reg[OUT_WIDTH-1:0];
    assign out_last  = act_vld & (beat_cnt == LAST_BEAT);
    assign busy      = act_vld | pend_vld;

    assign beat_xfer = act_vld & out_rdy;
    assign last_xfer = beat_xfer & (beat_cnt == LAST_BEAT);
    assign in_xfer   = in_vld & in_rdy;

    // NOTE: the data registers are reset too, so out_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state uses non-blocking assignments so every branch sees pre-edge values.
            act_reg  <= '0;
            pend_reg <= '0;
            act_vld  <= 1'b0;
            pend_vld <= 1'b0;
            beat_cnt <= '0;
        end else if (flush) begin
            act_vld  <= 1'b0;
            pend_vld <= 1'b0;
            beat_cnt <= '0;
        end else if (last_xfer) begin
            // Word boundary: refill from pend first, else straight from the input.
            beat_cnt <= '0;
            if (pend_vld) begin
                act_reg  <= pend_reg;
                pend_vld <= 1'b0;
            end else if (in_xfer) begin
                act_reg <= in_data;
            end else begin
                act_vld <= 1'b0;
            end
        end else begin
            if (beat_xfer) begin
                act_reg  <= act_reg >> OUT_WIDTH;
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (in_xfer) begin
                if (!act_vld) begin
                    act_reg  <= in_data;
                    act_vld  <= 1'b1;
                    beat_cnt <= '0;
                end else begin
                    pend_reg <= in_data;
                    pend_vld <= 1'b1;
                end
            end
        end
    end

`ifdef W2N_UNDERRUN_CNT_EN
    logic        urun_armed;
    logic [15:0] urun_cnt;

    // Counting starts only once a word has arrived, so idle time before the first frame is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            urun_armed <= 1'b0;
            urun_cnt   <= '0;
        end else if (flush) begin
            urun_armed <= 1'b0;
            urun_cnt   <= '0;
        end else begin
            if (in_xfer) begin
                urun_armed <= 1'b1;
            end
            if (urun_armed && out_rdy && !act_vld && (urun_cnt != 16'hFFFF)) begin
                urun_cnt <= urun_cnt + 16'd1;
            end
        end
    end

    assign underrun_cnt = urun_cnt;
`endif

endmodule

// File: tb/tb_wide2narrow_gearbox.sv
// Scoreboard bench for wide2narrow_gearbox: driver pushes expected beats, monitor pops and compares.
module tb_wide2narrow_gearbox;

    localparam int IN_W  = 256;
    localparam int OUT_W = 16;
    localparam int RATIO = IN_W / OUT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_vld;
    logic             in_rdy;
    logic [IN_W-1:0]  in_data;
    logic             out_vld;
    logic             out_rdy;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             busy;
`ifdef W2N_UNDERRUN_CNT_EN
    logic [15:0]      underrun_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit rdy_rand = 1'b0;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;
    beat_t exp_q[$];

    wide2narrow_gearbox #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy)
`ifdef W2N_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Word id places {id, k} into beat k, so every beat value is known by construction.
    function automatic logic [IN_W-1:0] mk_word(input logic [7:0] id);
        logic [IN_W-1:0] w;
        w = '0;
        for (int k = 0; k < RATIO; k++) w[k*OUT_W +: OUT_W] = {id, 8'(k)};
        return w;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send_word(input logic [7:0] id);
        int n;
        n = 0;
        in_vld  = 1'b1;
        in_data = mk_word(id);
        #2;
        while (!in_rdy && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!in_rdy) begin
            check("send_timeout", 32'(n), 32'd0);
        end else begin
            for (int k = 0; k < RATIO; k++) exp_q.push_back('{data: {id, 8'(k)}, last: (k == RATIO - 1)});
        end
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            tick();
            n++;
        end
        #1;
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    // out_rdy driver: held high, or pseudo-random 50% when rdy_rand is set.
    initial begin
        out_rdy = 1'b1;
        forever begin
            @(negedge clk);
            out_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares whenever a beat is presented, pops on handshake.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (exp_q.size() > RATIO) check("in_rdy_pend_full", 32'(in_rdy), 32'd0);
                if (out_vld) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q[0];
                        check("beat_data", 32'(out_data), 32'(e.data));
                        check("beat_last", 32'(out_last), 32'(e.last));
                        if (out_rdy) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        in_vld  = 1'b0;
        in_data = '0;
        #12;
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_rdy_low", 32'(in_rdy), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_in_rdy_high", 32'(in_rdy), 32'd1);
        tick();

        // 1: single word, beats 0x0000..0x000F in consecutive cycles
        send_word(8'h00);
        #1;
        check("t1_latency_vld", 32'(out_vld), 32'd1);
        check("t1_latency_data", 32'(out_data), 32'h0000);
        for (int i = 0; i < RATIO; i++) begin
            check("t1_contig_vld", 32'(out_vld), 32'd1);
            check("t1_contig_data", 32'(out_data), 32'(i));
            check("t1_last", 32'(out_last), 32'(i == RATIO - 1));
            tick();
            #1;
        end
        check("t1_done_vld", 32'(out_vld), 32'd0);
        check("t1_done_busy", 32'(busy), 32'd0);
        tick();

        // 2: four back-to-back words, no bubble across boundaries
        fork
            begin
                for (int w = 1; w <= 4; w++) send_word(8'(w));
            end
            begin
                int n;
                n = 0;
                #1;
                while (!out_vld && n < 10) begin
                    tick();
                    #1;
                    n++;
                end
                for (int i = 0; i < 4 * RATIO; i++) begin
                    check("t2_no_bubble", 32'(out_vld), 32'd1);
                    tick();
                    #1;
                end
                check("t2_end_vld", 32'(out_vld), 32'd0);
            end
        join
        drain("t2");
        tick();

        // 3: random backpressure over eight words
        rdy_rand = 1'b1;
        for (int w = 0; w < 8; w++) send_word(8'h40 + 8'(w));
        drain("t3");
        rdy_rand = 1'b0;
        tick();

        // 4: flush at beat 5 of word 0 with word 1 pending
        send_word(8'h10);
        send_word(8'h11);
        repeat (4) tick();
        #1;
        check("t4_pend_in_rdy", 32'(in_rdy), 32'd0);
        check("t4_beat5", 32'(out_data), 32'h1005);
        tick();
        flush = 1'b1;
        #1;
        check("t4_flush_in_rdy", 32'(in_rdy), 32'd0);
        tick();
        flush = 1'b0;
        exp_q.delete();
        #1;
        check("t4_post_vld", 32'(out_vld), 32'd0);
        check("t4_post_busy", 32'(busy), 32'd0);
        tick();
        send_word(8'h12);
        #1;
        check("t4_new_beat0", 32'(out_data), 32'h1200);
        drain("t4");
        tick();

        // 5: async reset at beat 9
        send_word(8'h20);
        repeat (9) tick();
        #1;
        check("t5_beat9", 32'(out_data), 32'h2009);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t5_rst_vld", 32'(out_vld), 32'd0);
        check("t5_rst_data", 32'(out_data), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("t5_rel_in_rdy", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("t5_no_stale", 32'(out_vld), 32'd0);
            tick();
            #1;
        end
        tick();

`ifdef W2N_UNDERRUN_CNT_EN
        // 6: underrun counter over 20 idle cycles, then flush
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send_word(8'h30);
        repeat (RATIO) tick();
        repeat (20) tick();
        #1;
        check("t6_underrun_20", 32'(underrun_cnt), 32'd20);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check("t6_underrun_flush", 32'(underrun_cnt), 32'd0);
        exp_q.delete();
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
